// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared types, default dimensions and the ReLU helper used by
//                the CNN activation-stage blocks.
//  Revision    : 1.0
// ============================================================================
package cnn_pkg;

    localparam int unsigned c_DATA_W = 8;
    localparam int unsigned c_H      = 256;
    localparam int unsigned c_W      = 256;
    localparam int unsigned c_C      = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Signed max(x, 0) on a two's-complement element.
    function automatic logic [c_DATA_W-1:0] relu(input logic [c_DATA_W-1:0] x);
        return ($signed(x) < 0) ? '0 : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/relu_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : relu_stream_ctrl_if
//  Description : Valid/ready element stream carrying ReLU results downstream.
//  Revision    : 1.0
// ============================================================================
interface relu_stream_ctrl_if #(
    parameter int unsigned DATA_W = 8
);
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/relu_stream_ctrl_skid_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : skid_fifo2
//  Description : Two-entry FIFO with data+last payload and synchronous flush.
//  Revision    : 1.0
// ============================================================================
module skid_fifo2 #(
    parameter int unsigned DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_flush,
    input  wire logic              i_push,
    input  wire logic [DATA_W-1:0] i_push_data,
    input  wire logic              i_push_last,
    input  wire logic              i_pop,
    output logic      [1:0]        o_count,
    output logic                   o_empty,
    output logic      [DATA_W-1:0] o_data,
    output logic                   o_last
);

    logic [DATA_W-1:0] r_data [2];
    logic              r_last [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_pop  = i_pop & (r_count != 2'd0);
    assign w_do_push = i_push & (~r_count[1] | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_last[0] <= 1'b0;
            r_last[1] <= 1'b0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_data[r_wr_ptr] <= i_push_data;
                r_last[r_wr_ptr] <= i_push_last;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The head slot is never the write slot while occupied, so the head holds.
    assign o_data  = r_data[r_rd_ptr];
    assign o_last  = r_last[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/relu_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : relu_stream_ctrl
//  Description : Walks an H x W x C int8 feature map, applies ReLU and streams
//                the results over valid/ready, counting zero-clipped elements.
//  Revision    : 1.0
// ============================================================================
module relu_stream_ctrl
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = c_DATA_W,
    parameter int unsigned H      = c_H,
    parameter int unsigned W      = c_W,
    parameter int unsigned C      = c_C,
    parameter int unsigned ADDR_W = 22,
    parameter int unsigned CNT_W  = 23
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic              abort,
    output logic                   rd_en,
    output logic      [ADDR_W-1:0] rd_addr,
    input  wire logic [DATA_W-1:0] rd_data,
    relu_stream_ctrl_if.master     m_if,
    output logic                   busy,
    output logic                   done,
    output logic      [CNT_W-1:0]  clip_cnt
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(H * W * C - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_inflight;
    logic              r_inflight_last;
    logic [CNT_W-1:0]  r_clip_cnt;

    logic [1:0]        w_fifo_count;
    logic              w_fifo_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_active;
    logic              w_kill;
    logic              w_go;
    logic              w_at_last;
    logic [2:0]        w_occ;
    logic [1:0]        w_left;
    logic [DATA_W-1:0] w_relu;
    logic              w_neg;

    assign w_pop     = m_if.m_valid & m_if.m_ready;
    assign w_active  = (r_state == RUN) || (r_state == DRAIN);
    assign w_kill    = abort & w_active;
    assign w_go      = start & ~abort & ((r_state == IDLE) || (r_state == DONE));
    assign w_at_last = (r_addr == c_LAST_ADDR);
    assign w_push    = r_inflight & ~w_kill;
    assign w_neg     = rd_data[DATA_W-1];

    // Credits: buffered + in-flight elements after this cycle's pop.
    assign w_occ  = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_left = w_fifo_count - {1'b0, w_pop};

    generate
        if (DATA_W == c_DATA_W) begin : g_relu_pkg
            assign w_relu = relu(rd_data);
        end else begin : g_relu_generic
            assign w_relu = w_neg ? '0 : rd_data;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        rd_en       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                rd_en = ~abort & (w_occ < 3'd2);
                if (w_kill) begin
                    w_state_nxt = IDLE;
                end else if (rd_en && w_at_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (w_kill) begin
                    w_state_nxt = IDLE;
                end else if (!r_inflight && (w_left == 2'd0)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = w_go ? RUN : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_clip_cnt      <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_inflight      <= rd_en;
            r_inflight_last <= rd_en & w_at_last;
            if (w_go) begin
                r_addr     <= '0;
                r_clip_cnt <= '0;
            end else begin
                if (rd_en && !w_at_last) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
                if (w_push && w_neg) begin
                    r_clip_cnt <= r_clip_cnt + CNT_W'(1);
                end
            end
        end
    end

    skid_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (w_kill),
        .i_push      (w_push),
        .i_push_data (w_relu),
        .i_push_last (r_inflight_last),
        .i_pop       (w_pop),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty),
        .o_data      (m_if.m_data),
        .o_last      (m_if.m_last)
    );

    assign m_if.m_valid = ~w_fifo_empty;
    assign rd_addr      = r_addr;
    assign clip_cnt     = r_clip_cnt;

endmodule
`default_nettype wire

// File: tb/tb_relu_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_relu_stream_ctrl
//  Description : Self-checking bench for relu_stream_ctrl on a 2x2x2 map.
//  Revision    : 1.0
// ============================================================================
module tb_relu_stream_ctrl;

    localparam int DW = 8;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [CW-1:0] clip_cnt;

    relu_stream_ctrl_if #(.DATA_W(DW)) s_if ();

    relu_stream_ctrl #(
        .DATA_W (DW),
        .H      (2),
        .W      (2),
        .C      (2),
        .ADDR_W (AW),
        .CNT_W  (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .m_if     (s_if.master),
        .busy     (busy),
        .done     (done),
        .clip_cnt (clip_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [N];

    // Feature buffer: data valid one cycle after the strobe, junk otherwise.
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : DW'($urandom);

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] v);
        return ($signed(v) < 0) ? '0 : v;
    endfunction

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       return cyc > 10;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"},   32'(rd_en),       0);
        check({tag, "_rd_addr"}, 32'(rd_addr),     0);
        check({tag, "_m_valid"}, 32'(s_if.m_valid), 0);
        check({tag, "_m_data"},  32'(s_if.m_data),  0);
        check({tag, "_m_last"},  32'(s_if.m_last),  0);
        check({tag, "_busy"},    32'(busy),        0);
        check({tag, "_done"},    32'(done),        0);
        check({tag, "_clip"},    32'(clip_cnt),    0);
    endtask

    // One pass: mode picks the m_ready pattern, abort_at aborts on that
    // accepted element (0 = never), restart_at pulses start mid-pass.
    task automatic run_pass(input int mode, input int abort_at, input int restart_at);
        int          got = 0;
        int          issued = 0;
        int          done_cnt = 0;
        int          done_cyc = -1;
        int          abort_cyc = -1;
        int          exp_clip = 0;
        int          issue_cyc [N];
        bit          finished = 0;
        bit          prev_hold = 0;
        logic [DW-1:0] prev_data = '0;
        logic        prev_last = 1'b0;
        bit          hs;

        for (int i = 0; i < N; i++) issue_cyc[i] = 1 << 30;

        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            @(negedge clk);
            start       = (cyc == 0) || (cyc == restart_at);
            abort       = 1'b0;
            s_if.m_ready = ready_for(mode, cyc);
            #1;
            hs = s_if.m_valid && s_if.m_ready;
            if (abort_at > 0 && hs && got + 1 == abort_at) begin
                abort     = 1'b1;
                abort_cyc = cyc;
                #1;
            end

            if (prev_hold) begin
                check("hold_valid", 32'(s_if.m_valid), 1);
                check("hold_data",  32'(s_if.m_data),  32'(prev_data));
                check("hold_last",  32'(s_if.m_last),  32'(prev_last));
            end
            if (hs && got < N) begin
                check("m_data", 32'(s_if.m_data), 32'(relu_ref(mem[got])));
                check("m_last", 32'(s_if.m_last), 32'(got == N - 1));
                got++;
            end
            prev_hold = s_if.m_valid && !s_if.m_ready;
            prev_data = s_if.m_data;
            prev_last = s_if.m_last;

            if (rd_en) begin
                check("rd_addr",   32'(rd_addr), 32'(issued));
                check("rd_credit", 32'((issued - got) < 2), 1);
                check("rd_overrun", 32'(issued < N), 1);
                if (issued < N) issue_cyc[issued] = cyc;
                issued++;
            end

            if (mode == 2 && cyc == 10) begin
                check("stall_reads",  32'(issued), 2);
                check("stall_valid",  32'(s_if.m_valid), 1);
            end

            if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                check("abort_valid", 32'(s_if.m_valid), 0);
                check("abort_busy",  32'(busy), 0);
                check("abort_done",  32'(done), 0);
            end
            if (abort_cyc >= 0 && cyc == abort_cyc + 3) finished = 1;

            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_all_out", 32'(got), N);
                check("done_busy",    32'(busy), 0);
                finished = 1;
            end
        end
        abort = 1'b0;
        start = 1'b0;

        if (!finished) check("pass_timeout", 0, 1);

        if (abort_at > 0) begin
            // Only returns that landed before the abort cycle are counted.
            for (int a = 0; a < N; a++)
                if (issue_cyc[a] <= abort_cyc - 2 && $signed(mem[a]) < 0) exp_clip++;
            check("abort_clip",     32'(clip_cnt), 32'(exp_clip));
            check("abort_no_done",  32'(done_cnt), 0);
        end else begin
            for (int a = 0; a < N; a++)
                if ($signed(mem[a]) < 0) exp_clip++;
            check("done_pulses", 32'(done_cnt), 1);
            check("reads_total", 32'(issued), N);
            check("clip_cnt",    32'(clip_cnt), 32'(exp_clip));
            if (mode == 0) check("done_cycle", 32'(done_cyc), N + 3);
            @(negedge clk);
            #1;
            check("post_done", 32'(done), 0);
            check("post_busy", 32'(busy), 0);
        end
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        s_if.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        mem = '{8'd5, 8'hFD, 8'd0, 8'd127, 8'h80, 8'd1, 8'hFF, 8'd64};
        run_pass(0, 0, -1);
        check("directed_clip", 32'(clip_cnt), 3);
        run_pass(1, 0, -1);
        run_pass(2, 0, -1);

        randomize_mem();
        run_pass(0, 4, -1);
        check("after_abort_busy", 32'(busy), 0);
        run_pass(0, 0, -1);

        randomize_mem();
        run_pass(0, 0, 5);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("start_abort_busy", 32'(busy), 0);
        check("start_abort_rd",   32'(rd_en), 0);
        @(negedge clk);
        #1;
        check("start_abort_busy2",  32'(busy), 0);
        check("start_abort_valid",  32'(s_if.m_valid), 0);

        randomize_mem();
        @(negedge clk);
        start        = 1'b1;
        s_if.m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_idle_busy",  32'(busy), 0);
            check("rst_idle_rd",    32'(rd_en), 0);
            check("rst_idle_valid", 32'(s_if.m_valid), 0);
        end

        for (int p = 0; p < 3; p++) begin
            randomize_mem();
            run_pass(3, 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
